echo_delay_line: RTL and testbench
==================================

ECHO_DELAY_LINE -- requirements
Module: echo_delay_line

Interface
REQ-001 SHALL have parameter SLOTS, default 16: number of pending echo event slots (2..64).
REQ-002 SHALL have parameter DELAY_W, default 24: width of the timestamp counter and the delay input.
REQ-003 SHALL have parameter MAX_REP, default 4: upper bound on echo repeats per input event (1..15).
REQ-004 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-005 SHALL have ports: reset_n  in  1  reset, asynchronous and active-low.
REQ-006 SHALL have ports: en  in  1  global enable; low freezes all state.
REQ-007 SHALL have ports: in_valid  in  1  one-cycle strobe, event present.
REQ-008 SHALL have ports: in_on  in  1  1 = note-on event, 0 = note-off event.
REQ-009 SHALL have ports: in_note  in  7  MIDI note; in_vel  in  7  velocity; in_pb  in  9  pitch-bend.
REQ-010 SHALL have ports: delay  in  DELAY_W  echo spacing in clk cycles, sampled per event at acceptance.
REQ-011 SHALL have ports: repeats  in  4  echoes per event, sampled at acceptance, clamped to 1..MAX_REP.
REQ-012 SHALL have ports: decay_sh  in  3  per-repeat velocity decay shift, sampled at acceptance.
REQ-013 SHALL have ports: out_valid  out  1  one-cycle strobe; out_on  out  1; out_note  out  7; out_vel  out  7; out_pb  out  9.
REQ-014 SHALL have ports: busy  out  1  any slot occupied; overflow  out  1  one-cycle pulse, event dropped.

Function
REQ-015 SHALL run a free-running DELAY_W-bit timestamp counter, +1 per enabled cycle, wrapping modulo 2^DELAY_W.
REQ-016 On accepted in_valid at cycle T, SHALL store the event in the lowest-index free slot with due = now + max(delay,1) and rem = clamped repeats.
REQ-017 Stored velocity for note-on: in_vel>>1, clamped to a minimum of 1 when in_vel>0. For note-off: 0.
REQ-018 A slot is due when (now - due), taken as a DELAY_W-bit value, has MSB clear. This makes comparison wrap-safe and catches missed deadlines.
REQ-019 Each cycle SHALL emit at most one event: the lowest-index due slot. The other due slots wait; they stay due and fire on later cycles.
REQ-020 On emission, SHALL register the slot's fields to the outputs and pulse out_valid in the following cycle. First echo latency is therefore D+1 cycles from in_valid.
REQ-021 After emission, if rem>1, SHALL reschedule the slot:
  - due += stored delay; rem -= 1;
  - for note-on, if decay_sh != 0: vel = vel - (vel>>decay_sh); vel never reaches 0.
  Otherwise the slot SHALL be freed.
REQ-022 decay_sh = 0 SHALL mean no decay. Note-off chains SHALL repeat the same count as their note-on chains.
REQ-023 If all slots are occupied when in_valid arrives, SHALL drop the event and pulse overflow for one cycle. Existing slots are unaffected.
REQ-024 Same-cycle acceptance and emission/freeing SHALL both take effect. A slot freed this cycle is not reusable until the next cycle.
REQ-025 Output fields SHALL hold their last values while out_valid is low.
REQ-026 With en low: counter holds, no acceptance, no emission, out_valid=0, overflow=0, slot contents retained. in_valid during en low is ignored.
REQ-027 busy SHALL be the OR of all slot-occupied flags, registered.

Reset
REQ-028 reset_n low SHALL asynchronously clear:
  - counter to 0;
  - all slot-occupied flags to 0;
  - out_valid, out_on, out_note, out_vel, out_pb, busy and overflow to 0.
REQ-029 Reset asserted mid-operation SHALL discard all pending echoes; no output event follows deassertion until a new in_valid.

Structure
REQ-030 Package echo_pkg SHALL hold:
  - the echo_slot_t struct (occupied, on, note, vel, pb, due, delay, rem, decay_sh);
  - default parameter constants;
  - a decay function.
REQ-031 SHALL instantiate one sub-module, echo_slot_arb: a parametrised lowest-index priority encoder, used twice (free-slot selection and due-slot selection). It outputs index and found flag.

Verification
REQ-032 Single event. in_valid on=1 note=60 vel=100 delay=10 repeats=3 decay_sh=1 at T -> out_valid at T+11, T+21, T+31 with vel 50, 25, 13; busy drops after last.
REQ-033 Note-off chain. Note-on at T, note-off at T+5 (delay=10, repeats=2) -> on/off alternating at T+11, T+16, T+21, T+26; off events vel=0.
REQ-034 Overflow. SLOTS=4: 5 in_valid strobes on consecutive cycles -> overflow pulse on the 5th only; exactly 4 chains emitted.
REQ-035 Collision. Two events accepted on consecutive cycles with delays 11 and 10 -> both due at the same cycle; lower slot emits first, the other emits one cycle later; no loss.
REQ-036 Wrap and freeze. Counter preset near 2^DELAY_W-3, delay=8 -> echo fires correctly across wrap. Holding en low 5 cycles mid-chain -> emission delayed exactly 5 cycles.
REQ-037 Reset mid-chain. reset_n pulsed low between repeats -> all outputs 0 immediately; no further out_valid.

Source files
------------

// File: rtl/echo_pkg.sv
// Shared types, parameter defaults and velocity decay helper for the echo delay line.
package echo_pkg;

    localparam int SLOTS_DEF   = 16;
    localparam int DELAY_W_DEF = 24;
    localparam int MAX_REP_DEF = 4;

    // Time fields are sized for the widest supported counter; only the low DELAY_W bits carry data.
    localparam int TS_W = 32;

    typedef struct packed {
        logic            occupied;
        logic            on;
        logic [6:0]      note;
        logic [6:0]      vel;
        logic [8:0]      pb;
        logic [TS_W-1:0] due;
        logic [TS_W-1:0] delay;
        logic [3:0]      rem;
        logic [2:0]      decay_sh;
    } echo_slot_t;

    // Shift 0 means no decay; a non-zero velocity never decays to zero.
    function automatic logic [6:0] decay_vel(input logic [6:0] vel, input logic [2:0] sh);
        logic [6:0] nv;
        nv = vel - (vel >> sh);
        if (sh == 3'd0) begin
            nv = vel;
        end else if ((nv == 7'd0) && (vel != 7'd0)) begin
            nv = 7'd1;
        end
        return nv;
    endfunction

endpackage

// File: rtl/echo_slot_arb.sv
// Lowest-index priority encoder over a request vector.
// Purely combinational, zero latency; no flow control.
module echo_slot_arb #(
    parameter int N     = 16,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             found_o
);

    always_comb begin
        idx_o   = '0;
        found_o = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o   = IDX_W'(i);
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/echo_delay_line.sv
// Echo delay line: replays note events as delayed, decaying repeats; first echo D+1 cycles after acceptance.
// One emission per cycle, no backpressure: a new event with no free slot is dropped and flagged on overflow.
module echo_delay_line
    import echo_pkg::*;
#(
    parameter int SLOTS   = SLOTS_DEF,
    parameter int DELAY_W = DELAY_W_DEF,
    parameter int MAX_REP = MAX_REP_DEF
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               en,
    input  logic               in_valid,
    input  logic               in_on,
    input  logic [6:0]         in_note,
    input  logic [6:0]         in_vel,
    input  logic [8:0]         in_pb,
    input  logic [DELAY_W-1:0] delay,
    input  logic [3:0]         repeats,
    input  logic [2:0]         decay_sh,
    output logic               out_valid,
    output logic               out_on,
    output logic [6:0]         out_note,
    output logic [6:0]         out_vel,
    output logic [8:0]         out_pb,
    output logic               busy,
    output logic               overflow
);

    localparam int              IDX_W   = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam logic [TS_W-1:0] TS_MASK = {TS_W{1'b1}} >> (TS_W - DELAY_W);
    localparam logic [TS_W-1:0] TS_HALF = TS_W'(1) << (DELAY_W - 1);
    localparam logic [3:0]      REP_MAX = 4'(MAX_REP);

    echo_slot_t         slot_q [SLOTS];
    echo_slot_t         slot_d [SLOTS];
    logic [DELAY_W-1:0] now_q, now_d;
    logic               out_valid_q, out_valid_d;
    logic               out_on_q, out_on_d;
    logic [6:0]         out_note_q, out_note_d;
    logic [6:0]         out_vel_q, out_vel_d;
    logic [8:0]         out_pb_q, out_pb_d;
    logic               busy_q, busy_d;
    logic               overflow_q, overflow_d;

    logic [TS_W-1:0]    now_ext;
    logic [SLOTS-1:0]   free_req, due_req;
    logic [IDX_W-1:0]   free_idx, due_idx;
    logic               free_found, due_found;
    echo_slot_t         new_slot, emit_slot;
    logic [TS_W-1:0]    new_dly;
    logic [3:0]         new_rem;
    logic [6:0]         new_vel;

    assign now_ext = TS_W'(now_q);

    // A slot is due once (now - due) is non-negative in DELAY_W-bit two's complement.
    always_comb begin
        for (int i = 0; i < SLOTS; i++) begin
            free_req[i] = ~slot_q[i].occupied;
            due_req[i]  = slot_q[i].occupied && (((now_ext - slot_q[i].due) & TS_HALF) == '0);
        end
    end

    echo_slot_arb #(.N(SLOTS), .IDX_W(IDX_W)) u_free_arb (
        .req_i   (free_req),
        .idx_o   (free_idx),
        .found_o (free_found)
    );

    echo_slot_arb #(.N(SLOTS), .IDX_W(IDX_W)) u_due_arb (
        .req_i   (due_req),
        .idx_o   (due_idx),
        .found_o (due_found)
    );

    always_comb begin
        new_dly = (delay == '0) ? TS_W'(1) : TS_W'(delay);
        if (repeats == 4'd0) begin
            new_rem = 4'd1;
        end else if (repeats > REP_MAX) begin
            new_rem = REP_MAX;
        end else begin
            new_rem = repeats;
        end
        new_vel = '0;
        if (in_on) begin
            new_vel = (in_vel > 7'd1) ? (in_vel >> 1) : in_vel;
        end
        new_slot.occupied = 1'b1;
        new_slot.on       = in_on;
        new_slot.note     = in_note;
        new_slot.vel      = new_vel;
        new_slot.pb       = in_pb;
        new_slot.due      = (now_ext + new_dly) & TS_MASK;
        new_slot.delay    = new_dly;
        new_slot.rem      = new_rem;
        new_slot.decay_sh = decay_sh;
    end

    always_comb begin
        slot_d      = slot_q;
        now_d       = now_q;
        emit_slot   = slot_q[due_idx];
        out_valid_d = 1'b0;
        overflow_d  = 1'b0;
        out_on_d    = out_on_q;
        out_note_d  = out_note_q;
        out_vel_d   = out_vel_q;
        out_pb_d    = out_pb_q;
        if (en) begin
            now_d = now_q + DELAY_W'(1);
            if (due_found) begin
                out_valid_d = 1'b1;
                out_on_d    = emit_slot.on;
                out_note_d  = emit_slot.note;
                out_vel_d   = emit_slot.vel;
                out_pb_d    = emit_slot.pb;
                // Reschedule on the original grid so a late emission does not drift the chain.
                if (emit_slot.rem > 4'd1) begin
                    slot_d[due_idx].due = (emit_slot.due + emit_slot.delay) & TS_MASK;
                    slot_d[due_idx].rem = emit_slot.rem - 4'd1;
                    if (emit_slot.on) begin
                        slot_d[due_idx].vel = decay_vel(emit_slot.vel, emit_slot.decay_sh);
                    end
                end else begin
                    slot_d[due_idx].occupied = 1'b0;
                end
            end
            if (in_valid) begin
                if (free_found) begin
                    slot_d[free_idx] = new_slot;
                end else begin
                    overflow_d = 1'b1;
                end
            end
        end
        busy_d = 1'b0;
        for (int i = 0; i < SLOTS; i++) begin
            busy_d = busy_d | slot_d[i].occupied;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            now_q <= '0;
            for (int i = 0; i < SLOTS; i++) begin
                slot_q[i] <= '0;
            end
            out_valid_q <= 1'b0;
            out_on_q    <= 1'b0;
            out_note_q  <= '0;
            out_vel_q   <= '0;
            out_pb_q    <= '0;
            busy_q      <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            now_q       <= now_d;
            slot_q      <= slot_d;
            out_valid_q <= out_valid_d;
            out_on_q    <= out_on_d;
            out_note_q  <= out_note_d;
            out_vel_q   <= out_vel_d;
            out_pb_q    <= out_pb_d;
            busy_q      <= busy_d;
            overflow_q  <= overflow_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_on    = out_on_q;
    assign out_note  = out_note_q;
    assign out_vel   = out_vel_q;
    assign out_pb    = out_pb_q;
    assign busy      = busy_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_echo_delay_line.sv
// Testbench for echo_delay_line: scoreboard of expected echoes, checked against DUT output strobes.
`timescale 1ns/1ps
module tb_echo_delay_line;

    localparam int SLOTS   = 4;
    localparam int DELAY_W = 8;
    localparam int MAX_REP = 4;

    logic               clk      = 1'b0;
    logic               reset_n  = 1'b0;
    logic               en       = 1'b1;
    logic               in_valid = 1'b0;
    logic               in_on    = 1'b0;
    logic [6:0]         in_note  = '0;
    logic [6:0]         in_vel   = '0;
    logic [8:0]         in_pb    = '0;
    logic [DELAY_W-1:0] delay    = '0;
    logic [3:0]         repeats  = '0;
    logic [2:0]         decay_sh = '0;
    logic               out_valid, out_on, busy, overflow;
    logic [6:0]         out_note, out_vel;
    logic [8:0]         out_pb;

    int         checks = 0;
    int         errors = 0;
    int         cyc    = 0;
    logic [7:0] tb_ts  = '0;

    typedef struct {
        int         cyc;
        logic       on;
        logic [6:0] note;
        logic [6:0] vel;
        logic [8:0] pb;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    echo_delay_line #(.SLOTS(SLOTS), .DELAY_W(DELAY_W), .MAX_REP(MAX_REP)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .en       (en),
        .in_valid (in_valid),
        .in_on    (in_on),
        .in_note  (in_note),
        .in_vel   (in_vel),
        .in_pb    (in_pb),
        .delay    (delay),
        .repeats  (repeats),
        .decay_sh (decay_sh),
        .out_valid(out_valid),
        .out_on   (out_on),
        .out_note (out_note),
        .out_vel  (out_vel),
        .out_pb   (out_pb),
        .busy     (busy),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference timestamp: counts enabled cycles since reset, modulo 2^DELAY_W.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) tb_ts <= '0;
        else if (en)  tb_ts <= tb_ts + 8'd1;
    end

    always @(negedge clk) begin
        if (reset_n && out_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_echo cyc=%0d on=%0b note=%0d vel=%0d pb=%0d, none expected",
                         cyc, out_on, out_note, out_vel, out_pb);
            end else begin
                mon_e = exp_q.pop_front();
                if (cyc != mon_e.cyc || out_on !== mon_e.on || out_note !== mon_e.note ||
                    out_vel !== mon_e.vel || out_pb !== mon_e.pb) begin
                    errors++;
                    $display("FAIL echo got cyc=%0d on=%0b note=%0d vel=%0d pb=%0d want cyc=%0d on=%0b note=%0d vel=%0d pb=%0d",
                             cyc, out_on, out_note, out_vel, out_pb,
                             mon_e.cyc, mon_e.on, mon_e.note, mon_e.vel, mon_e.pb);
                end
            end
        end
    end

    task automatic push_exp(input int c, input logic on, input int note, input int vel, input int pb);
        exp_t e;
        e.cyc  = c;
        e.on   = on;
        e.note = 7'(note);
        e.vel  = 7'(vel);
        e.pb   = 9'(pb);
        exp_q.push_back(e);
    endtask

    // Drives one in_valid cycle; t is the cycle index holding the strobe.
    task automatic send(input logic on, input int note, input int vel, input int pb,
                        input int dly, input int rep, input int dsh, output int t);
        in_valid = 1'b1;
        in_on    = on;
        in_note  = 7'(note);
        in_vel   = 7'(vel);
        in_pb    = 9'(pb);
        delay    = DELAY_W'(dly);
        repeats  = 4'(rep);
        decay_sh = 3'(dsh);
        t        = cyc;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({out_valid, out_on, out_note, out_vel, out_pb} !== 25'd0) begin
            errors++;
            $display("FAIL reset_outputs got=%h want=0", {out_valid, out_on, out_note, out_vel, out_pb});
        end
        checks++;
        if ({busy, overflow} !== 2'b00) begin
            errors++;
            $display("FAIL reset_flags busy=%0b overflow=%0b want 0 0", busy, overflow);
        end
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single();
        int t;
        send(1'b1, 60, 100, 300, 10, 3, 1, t);
        push_exp(t + 11, 1'b1, 60, 50, 300);
        push_exp(t + 21, 1'b1, 60, 25, 300);
        push_exp(t + 31, 1'b1, 60, 13, 300);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got=%0b want=1", busy); end
        wait_until(t + 40);
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL single_pending got=%0d want=0", exp_q.size()); end
        checks++;
        if ({out_valid, out_on, out_note, out_vel, out_pb} !== {1'b0, 1'b1, 7'd60, 7'd13, 9'd300}) begin
            errors++;
            $display("FAIL single_hold got v=%0b note=%0d vel=%0d pb=%0d want v=0 note=60 vel=13 pb=300",
                     out_valid, out_note, out_vel, out_pb);
        end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL single_idle busy=%0b want=0", busy); end
        exp_q.delete();
    endtask

    task automatic test_back_to_back();
        int t;
        send(1'b1, 70, 1, 5, 0, 9, 2, t);
        for (int k = 0; k < MAX_REP; k++) push_exp(t + 2 + k, 1'b1, 70, 1, 5);
        wait_until(t + 12);
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_pending got=%0d want=0", exp_q.size()); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle busy=%0b want=0", busy); end
        exp_q.delete();
    endtask

    task automatic test_note_off();
        int t, t2;
        send(1'b1, 62, 80, 100, 10, 2, 0, t);
        wait_until(t + 5);
        send(1'b0, 62, 64, 100, 10, 2, 0, t2);
        push_exp(t + 11, 1'b1, 62, 40, 100);
        push_exp(t2 + 11, 1'b0, 62, 0, 100);
        push_exp(t + 21, 1'b1, 62, 40, 100);
        push_exp(t2 + 21, 1'b0, 62, 0, 100);
        wait_until(t + 35);
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL noteoff_pending got=%0d want=0", exp_q.size()); end
        exp_q.delete();
    endtask

    task automatic test_overflow();
        int   ts[5];
        logic want_ov;
        for (int i = 0; i < 5; i++) begin
            send(1'b1, 40 + i, 90, 0, 10, 1, 0, ts[i]);
            want_ov = (i == 4);
            checks++;
            if (overflow !== want_ov) begin
                errors++;
                $display("FAIL overflow_pulse strobe=%0d got=%0b want=%0b", i, overflow, want_ov);
            end
        end
        for (int i = 0; i < 4; i++) push_exp(ts[i] + 11, 1'b1, 40 + i, 45, 0);
        @(negedge clk);
        checks++;
        if (overflow !== 1'b0) begin errors++; $display("FAIL overflow_clear got=%0b want=0", overflow); end
        wait_until(ts[4] + 20);
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL overflow_pending got=%0d want=0", exp_q.size()); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL overflow_idle busy=%0b want=0", busy); end
        exp_q.delete();
    endtask

    task automatic test_collision();
        int ta, tb;
        send(1'b1, 50, 60, 1, 11, 1, 0, ta);
        send(1'b1, 51, 70, 2, 10, 1, 0, tb);
        push_exp(ta + 12, 1'b1, 50, 30, 1);
        push_exp(ta + 13, 1'b1, 51, 35, 2);
        wait_until(ta + 20);
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL collision_pending got=%0d want=0", exp_q.size()); end
        exp_q.delete();
    endtask

    task automatic test_wrap();
        int t;
        int guard = 0;
        while (tb_ts != 8'd253 && guard < 600) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (tb_ts != 8'd253) begin errors++; $display("FAIL wrap_align ts=%0d want=253", tb_ts); end
        send(1'b1, 72, 20, 7, 8, 2, 0, t);
        push_exp(t + 9, 1'b1, 72, 10, 7);
        push_exp(t + 17, 1'b1, 72, 10, 7);
        wait_until(t + 25);
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL wrap_pending got=%0d want=0", exp_q.size()); end
        exp_q.delete();
    endtask

    task automatic test_freeze();
        int t, tx;
        send(1'b1, 64, 40, 1, 10, 2, 0, t);
        push_exp(t + 11, 1'b1, 64, 20, 1);
        push_exp(t + 26, 1'b1, 64, 20, 1);
        wait_until(t + 13);
        en = 1'b0;
        @(negedge clk);
        send(1'b1, 99, 99, 0, 3, 1, 0, tx);
        checks++;
        if ({busy, overflow, out_valid} !== 3'b100) begin
            errors++;
            $display("FAIL freeze_state busy=%0b overflow=%0b out_valid=%0b want 1 0 0", busy, overflow, out_valid);
        end
        wait_until(t + 18);
        en = 1'b1;
        wait_until(t + 34);
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL freeze_pending got=%0d want=0", exp_q.size()); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL freeze_idle busy=%0b want=0", busy); end
        exp_q.delete();
    endtask

    task automatic test_reset_mid();
        int t;
        send(1'b1, 66, 100, 2, 10, 3, 1, t);
        push_exp(t + 11, 1'b1, 66, 50, 2);
        wait_until(t + 15);
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL rstmid_first got=%0d pending want=0", exp_q.size()); end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, out_on, out_note, out_vel, out_pb, busy, overflow} !== 27'd0) begin
            errors++;
            $display("FAIL rstmid_outputs got=%h want=0",
                     {out_valid, out_on, out_note, out_vel, out_pb, busy, overflow});
        end
        exp_q.delete();
        @(negedge clk);
        reset_n = 1'b1;
        wait_until(t + 60);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_idle busy=%0b want=0", busy); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_note_off();
        test_overflow();
        test_collision();
        test_wrap();
        test_freeze();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
